message_sequencer: RTL and testbench
====================================

MESSAGE_SEQUENCER -- requirements
Module: message_sequencer

Interface
REQ-001 Parameter READY_FRAMES, default 180, frames the "get ready" screen is held (3 s at 60 Hz).
REQ-002 Parameter TICKS_PER_SEC, default 60, frame ticks per game second.
REQ-003 Parameter PLAY_SECONDS, default 60, game duration in seconds; range 1..127.
REQ-004 Parameter TIMESUP_FRAMES, default 120, frames the "time is up" screen is held.
REQ-005 Parameter BOARD_FRAMES, default 600, frames the house-cup leaderboard is held.
REQ-006 Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-007 clk  input  1  system/pixel clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 frame_tick  input  1  one-cycle pulse per VGA frame, synchronous to clk.
REQ-010 start  input  1  level or pulse; requests a new game.
REQ-011 skip  input  1  one-cycle pulse; advances the current timed screen early.
REQ-012 abort  input  1  one-cycle pulse; returns to idle from any state.
REQ-013 get_ready  output  1  selects "wand up" overlay in the letter block.
REQ-014 playing  output  1  high during gameplay.
REQ-015 times_up  output  1  selects "time is up" overlay.
REQ-016 leaderboard  output  1  selects "house cup" overlay.
REQ-017 seconds_left  output  7  remaining game seconds, unsigned.
REQ-018 state  output  3  encoded state: IDLE=0, READY=1, PLAY=2, TIMESUP=3, BOARD=4.

Function
REQ-019 FSM states: IDLE, READY, PLAY, TIMESUP, BOARD; codes 5-7 are unreachable and decode to IDLE on the next edge.
REQ-020 All outputs are registered; a transition decided at edge N is visible on outputs after edge N.
REQ-021 Overlay outputs are one-hot or all-zero: get_ready only in READY, playing only in PLAY, times_up only in TIMESUP, leaderboard only in BOARD.
REQ-022 A 10-bit frame counter counts frame_tick pulses within READY, TIMESUP and BOARD; it clears to 0 on every state entry.
REQ-023 IDLE->READY when start=1; start is ignored in all other states.
REQ-024 READY->PLAY on the frame_tick at which frame counter = READY_FRAMES-1.
REQ-025 PLAY entry loads seconds_left=PLAY_SECONDS and clears the second prescaler.
REQ-026 In PLAY the prescaler counts frame_tick pulses 0..TICKS_PER_SEC-1 and wraps; on the wrapping tick seconds_left decrements by 1.
REQ-027 PLAY->TIMESUP on the same edge at which seconds_left decrements from 1 to 0.
REQ-028 seconds_left holds 0 in TIMESUP, BOARD and IDLE; it never underflows.
REQ-029 TIMESUP->BOARD on the frame_tick at which frame counter = TIMESUP_FRAMES-1.
REQ-030 BOARD->IDLE on the frame_tick at which frame counter = BOARD_FRAMES-1.
REQ-031 skip in READY, TIMESUP or BOARD forces the normal next state on that edge; skip in PLAY or IDLE is ignored.
REQ-032 Priority on the same edge: abort > skip > timer expiry > start.
REQ-033 abort in any state forces IDLE, clears both counters, and sets seconds_left=0.
REQ-034 With no frame_tick pulses, state and counters hold indefinitely.
REQ-035 A frame_tick held high for k cycles counts as k ticks; debouncing is the source's responsibility.

Reset
REQ-036 reset=1 asynchronously forces state=IDLE, all overlay outputs and playing to 0, seconds_left=0, and both counters to 0.
REQ-037 Reset asserted mid-game discards all progress; after release, the next start begins from READY with full durations.

Verification
REQ-038 Reset released, start pulse -> get_ready=1 next cycle; after exactly 180 frame_ticks -> playing=1, seconds_left=60.
REQ-039 In PLAY, 60*60 ticks -> seconds_left steps 60..1, then times_up=1 with seconds_left=0 on the 3600th tick edge.
REQ-040 TIMESUP: 120 ticks -> leaderboard=1; 600 further ticks -> state=0, all overlays 0.
REQ-041 In READY, skip and abort on the same cycle -> IDLE; in PLAY, skip alone -> no change.
REQ-042 Reset asserted asynchronously between clock edges during PLAY with seconds_left=37 -> outputs zero immediately; a later start -> READY with a fresh 180-tick hold.
REQ-043 Every cycle, assert at most one of get_ready/playing/times_up/leaderboard is high, and that state never takes a value in 5-7.

Source files
------------

// File: rtl/message_sequencer_if.sv
// message_sequencer_if: control inputs and overlay/status outputs of the game message sequencer
// master: frame_tick, start, skip, abort out; overlay flags, seconds_left, state in
// slave:  the sequencer side, directions mirrored
`timescale 1ns/1ps
interface message_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       skip;
  logic       abort;
  logic       get_ready;
  logic       playing;
  logic       times_up;
  logic       leaderboard;
  logic [6:0] seconds_left;
  logic [2:0] state;
  modport master (
    output frame_tick, start, skip, abort,
    input  get_ready, playing, times_up, leaderboard, seconds_left, state
  );
  modport slave (
    input  frame_tick, start, skip, abort,
    output get_ready, playing, times_up, leaderboard, seconds_left, state
  );
endinterface

// File: rtl/message_sequencer.sv
// message_sequencer: frame-timed IDLE/READY/PLAY/TIMESUP/BOARD screen sequencer with game countdown
// clk, reset (async active-high) plain ports; bus.slave carries frame_tick/start/skip/abort in,
// get_ready/playing/times_up/leaderboard overlays, seconds_left and encoded state out
`timescale 1ns/1ps
module message_sequencer #(
  parameter int READY_FRAMES   = 180,
  parameter int TICKS_PER_SEC  = 60,
  parameter int PLAY_SECONDS   = 60,
  parameter int TIMESUP_FRAMES = 120,
  parameter int BOARD_FRAMES   = 600
) (
  input logic clk,
  input logic reset,
  message_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READY, PLAY, TIMESUP, BOARD} state_t;
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [9:0] RF = 10'(READY_FRAMES - 1);
  localparam logic [9:0] TF = 10'(TIMESUP_FRAMES - 1);
  localparam logic [9:0] BF = 10'(BOARD_FRAMES - 1);
  localparam logic [PW-1:0] TP = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] PS = 7'(PLAY_SECONDS);
  state_t st, st_n;
  logic [9:0] fc, fc_n;
  logic [PW-1:0] pre, pre_n;
  logic [6:0] sec, sec_n;
  logic wrap, tick_fc;
  always_comb begin
    wrap = bus.frame_tick && pre == TP;
    tick_fc = bus.frame_tick && st inside {READY, TIMESUP, BOARD};
    st_n = st;
    case (st)
      IDLE:    st_n = bus.start ? READY : IDLE;
      READY:   st_n = (bus.skip || (bus.frame_tick && fc == RF)) ? PLAY : READY;
      PLAY:    st_n = (wrap && sec == 7'd1) ? TIMESUP : PLAY;
      TIMESUP: st_n = (bus.skip || (bus.frame_tick && fc == TF)) ? BOARD : TIMESUP;
      BOARD:   st_n = (bus.skip || (bus.frame_tick && fc == BF)) ? IDLE : BOARD;
      default: st_n = IDLE;
    endcase
    if (bus.abort) st_n = IDLE;
    // any state change restarts the frame count, so every timed screen starts from 0
    fc_n = st_n != st ? '0 : fc + {9'd0, tick_fc};
    pre_n = (st_n != PLAY || st != PLAY) ? '0 : bus.frame_tick ? (wrap ? '0 : pre + PW'(1)) : pre;
    sec_n = st_n != PLAY ? '0 : st != PLAY ? PS : wrap ? sec - 7'd1 : sec;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      fc <= '0;
      pre <= '0;
      sec <= '0;
      bus.get_ready <= 1'b0;
      bus.playing <= 1'b0;
      bus.times_up <= 1'b0;
      bus.leaderboard <= 1'b0;
    end else begin
      st <= st_n;
      fc <= fc_n;
      pre <= pre_n;
      sec <= sec_n;
      bus.get_ready <= st_n == READY;
      bus.playing <= st_n == PLAY;
      bus.times_up <= st_n == TIMESUP;
      bus.leaderboard <= st_n == BOARD;
    end
  end
  assign bus.state = st;
  assign bus.seconds_left = sec;
endmodule

// File: tb/tb_message_sequencer.sv
// tb_message_sequencer: scoreboard bench for message_sequencer with directed game sequences
`timescale 1ns/1ps
module tb_message_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  message_sequencer_if bus();
  message_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {int c; logic [13:0] o;} exp_t;
  exp_t q[$];
  logic mon_en = 1'b0;
  logic [13:0] prev;
  wire [13:0] outs = {bus.state, bus.get_ready, bus.playing, bus.times_up, bus.leaderboard, bus.seconds_left};
  function automatic logic [13:0] ov(input logic [2:0] s, input logic [6:0] sec);
    return {s, s == 3'd1, s == 3'd2, s == 3'd3, s == 3'd4, sec};
  endfunction
  task automatic go(input logic t, input logic s, input logic k, input logic a);
    @(negedge clk);
    #1;
    bus.frame_tick = t;
    bus.start = s;
    bus.skip = k;
    bus.abort = a;
  endtask
  task automatic expect_out(input logic [2:0] s, input logic [6:0] sec);
    q.push_back('{c: cyc + 1, o: ov(s, sec)});
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) go(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic play(input int n, input bool_start);
    for (int i = 1; i <= n; i++) begin
      if (bool_start && i == 100) begin
        go(1'b0, 1'b0, 1'b1, 1'b0);
        go(1'b0, 1'b1, 1'b0, 1'b0);
      end
      go(1'b1, 1'b0, 1'b0, 1'b0);
      if (i % 60 == 0) expect_out(i == 3600 ? 3'd3 : 3'd2, 7'(60 - i / 60));
    end
  endtask
  task automatic chk(input string n, input logic [13:0] a, input logic [13:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s: outputs %h, required %h", n, a, r);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0({bus.get_ready, bus.playing, bus.times_up, bus.leaderboard}) || bus.state > 3'd4) begin
        errors++;
        $display("FAIL invariant: cycle %0d outputs %h, required one-hot overlays and state<5", cyc, outs);
      end
      if (outs !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cycle %0d outputs %h, required %h", cyc, outs, prev);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.c != cyc || e.o !== outs) begin
            errors++;
            $display("FAIL transition: cycle %0d outputs %h, required cycle %0d outputs %h", cyc, outs, e.c, e.o);
          end
        end
      end
    end
    prev = outs;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.skip = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_state", outs, 14'd0);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    go(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(3'd1, 7'd0);
    ticks(100);
    idle(5);
    ticks(79);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(3'd2, 7'd60);
    play(3600, 1'b1);
    ticks(119);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(3'd4, 7'd0);
    ticks(599);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(3'd0, 7'd0);
    idle(3);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(3'd1, 7'd0);
    ticks(5);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(3'd2, 7'd60);
    play(3600, 1'b0);
    ticks(50);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(3'd4, 7'd0);
    ticks(10);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(3'd0, 7'd0);
    idle(2);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(3'd1, 7'd0);
    ticks(3);
    go(1'b1, 1'b0, 1'b1, 1'b1);
    expect_out(3'd0, 7'd0);
    idle(2);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(3'd1, 7'd0);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(3'd2, 7'd60);
    play(1380, 1'b0);
    idle(2);
    @(posedge clk);
    #2;
    q.push_back('{c: cyc, o: ov(3'd0, 7'd0)});
    reset = 1'b1;
    #1;
    chk("async_reset", outs, 14'd0);
    idle(2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    go(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(3'd1, 7'd0);
    ticks(179);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(3'd2, 7'd60);
    ticks(59);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(3'd2, 7'd59);
    go(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(3'd0, 7'd0);
    idle(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected transitions unseen, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
